bip_ctrl_fsm: RTL
=================

// Module: bip_ctrl_fsm
// PURPOSE
//  Multi-cycle control unit for the BIP datapath; successor to the single-cycle opcode decoder.
//  - Sequences FETCH/DECODE/MEM/EXEC per instruction and latches the opcode.
//  - Waits on a data-memory ready handshake, with a wait-state timeout.
//  - Traps illegal opcodes; HLT halts the core.
//  - Drives the same datapath strobes (WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam) plus IR-load and status.
// PARAMETERS
//  OPCODE_W     5   opcode width; codes 00000..00111 = HLT,STO,LD,LDI,ADD,ADDI,SUB,SUBI
//  MEM_TIMEOUT  15  max cycles in MEM without i_mem_ready before ERR (>=1)
// PORTS
//  i_clk        in   1         clock, rising edge
//  i_reset      in   1         synchronous, active-high reset
//  i_start      in   1         IDLE->FETCH launch pulse
//  i_opcode     in   OPCODE_W  opcode from program memory, valid in DECODE
//  i_mem_ready  in   1         data memory completed access this cycle
//  i_acc_zero   in   1         ACC==0 flag (branch option only)
//  o_IrLd       out  1         load instruction register
//  o_WrPC       out  1         PC write enable
//  o_PcSel      out  1         0: PC+1, 1: PC<=operand (branch option only)
//  o_SelA       out  2         00 mem, 01 immediate, 10 ALU, 11 hold
//  o_SelB       out  1         ALU B: 0 mem data, 1 immediate
//  o_WrAcc      out  1         ACC write enable
//  o_Op         out  1         0 add, 1 subtract
//  o_WrRam      out  1         data-memory write request
//  o_RdRam      out  1         data-memory read request
//  o_busy       out  1         1 in FETCH/DECODE/MEM/EXEC
//  o_halted     out  1         1 in HALT
//  o_err        out  1         1 in ERR
// BEHAVIOUR
//  - Reset, sync: state=IDLE, opcode reg=0, wait counter=0. All strobes 0, SelA=11, status 0.
//  - Reset wins over every other event, including mid-MEM.
//  - States: IDLE, FETCH, DECODE, MEM, EXEC, HALT, ERR. Outputs are Moore, from state + latched opcode.
//  - IDLE: i_start=1 -> FETCH.
//  - FETCH: o_IrLd=1 -> DECODE.
//  - DECODE: latch i_opcode.
//    - HLT -> HALT.
//    - LDI/ADDI/SUBI -> EXEC.
//    - STO/LD/ADD/SUB -> MEM, counter cleared.
//    - Any other code -> ERR.
//  - MEM: RdRam=1 (LD/ADD/SUB) or WrRam=1 (STO), held every cycle until i_mem_ready=1 -> EXEC.
//    - Counter increments each non-ready cycle.
//    - Counter==MEM_TIMEOUT with ready still low -> ERR.
//    - Ready in the same cycle as the limit: ready wins.
//  - EXEC: one cycle, WrPC=1, then -> FETCH. Per opcode:
//    - LD: SelA=00, WrAcc=1.
//    - LDI: SelA=01, WrAcc=1.
//    - ADD/SUB: SelA=10, SelB=0, WrAcc=1, Op=0/1.
//    - ADDI/SUBI: SelA=10, SelB=1, WrAcc=1, Op=0/1.
//    - STO: SelA=11, WrAcc=0.
//    - RdRam remains 1 in EXEC for LD/ADD/SUB (data held).
//  - Latency: immediate op 3 cycles (FETCH, DECODE, EXEC); memory op 4+N cycles (N = wait cycles).
//  - HALT: all strobes 0, o_halted=1, i_start ignored. Sticky until reset.
//  - ERR: all strobes 0, o_err=1. Sticky until reset.
//  - o_SelA=11 in every state except EXEC.
// CONFIGURATION
//  BIP_BRANCH_EN defined:
//    - Opcodes 01000 BEQ, 01001 BNE, 01010 JMP: DECODE -> EXEC.
//    - EXEC: WrPC=1. o_PcSel=1 for JMP, for BEQ when i_acc_zero=1, for BNE when i_acc_zero=0; else 0.
//    - No ACC or RAM strobe.
//  BIP_BRANCH_EN undefined:
//    - Those codes are illegal -> ERR.
//    - o_PcSel tied 0; i_acc_zero unused.
// TESTING
//  1 Reset, pulse i_start, opcode 00011 (LDI) -> o_IrLd=1 in cycle 1; cycle 3 WrAcc=1, SelA=01, WrPC=1; cycle 4 FETCH.
//  2 ADD (00100), i_mem_ready after 3 low cycles -> RdRam=1 for 4 MEM cycles; EXEC SelA=10, SelB=0, Op=0, WrAcc=1.
//  3 LD, i_mem_ready stuck 0 -> ERR after 15 MEM cycles; o_err=1, all strobes 0; i_start no effect.
//  4 i_reset=1 in 2nd MEM cycle of STO -> next cycle IDLE, WrRam=0, SelA=11, o_busy=0.
//  5 HLT (00000) -> o_halted=1, WrPC=0; i_start pulses ignored until reset; opcode 11111 -> ERR.
//  6 With BIP_BRANCH_EN: BEQ, i_acc_zero=1 -> EXEC PcSel=1, WrPC=1; acc_zero=0 -> PcSel=0. Without it: BEQ -> ERR.

Source files
------------

// File: rtl/bip_ctrl_fsm_if.sv
// BIP control-unit bus: program/data-memory handshake inputs and datapath strobes.
// master = control unit side, slave = datapath/memory side.
interface bip_ctrl_fsm_if #(
    parameter int unsigned OPCODE_W = 5
);
    logic                i_start;
    logic [OPCODE_W-1:0] i_opcode;
    logic                i_mem_ready;
    logic                i_acc_zero;

    logic                o_IrLd;
    logic                o_WrPC;
    logic                o_PcSel;
    logic [1:0]          o_SelA;
    logic                o_SelB;
    logic                o_WrAcc;
    logic                o_Op;
    logic                o_WrRam;
    logic                o_RdRam;
    logic                o_busy;
    logic                o_halted;
    logic                o_err;

    modport master (
        input  i_start, i_opcode, i_mem_ready, i_acc_zero,
        output o_IrLd, o_WrPC, o_PcSel, o_SelA, o_SelB, o_WrAcc, o_Op,
        output o_WrRam, o_RdRam, o_busy, o_halted, o_err
    );

    modport slave (
        output i_start, i_opcode, i_mem_ready, i_acc_zero,
        input  o_IrLd, o_WrPC, o_PcSel, o_SelA, o_SelB, o_WrAcc, o_Op,
        input  o_WrRam, o_RdRam, o_busy, o_halted, o_err
    );
endinterface

// File: rtl/bip_ctrl_fsm.sv
// Multi-cycle control unit for the BIP datapath.
// Sequences FETCH/DECODE/MEM/EXEC, latches the opcode in DECODE, waits on the
// data-memory ready handshake with a wait-state timeout, traps illegal opcodes
// and halts on HLT. HALT and ERR are sticky until reset.
// Optional feature macro: BIP_BRANCH_EN (adds BEQ/BNE/JMP and drives o_PcSel).
module bip_ctrl_fsm #(
    parameter int unsigned OPCODE_W    = 5,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic               i_clk,
    input logic               i_reset,
    bip_ctrl_fsm_if.master    bus
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
    // Last non-ready MEM cycle allowed; one more without ready trips ERR.
    localparam logic [CntW-1:0] MemLimit = CntW'(MEM_TIMEOUT - 1);

    localparam logic [OPCODE_W-1:0] OpHlt  = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OpSto  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OpLd   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OpLdi  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OpAdd  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OpSub  = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OpSubi = OPCODE_W'(7);
`ifdef BIP_BRANCH_EN
    localparam logic [OPCODE_W-1:0] OpBeq  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OpBne  = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OpJmp  = OPCODE_W'(10);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StMem,
        StExec,
        StHalt,
        StErr
    } state_e;

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic op_is_rd;
    logic op_is_sto;

    assign op_is_rd  = (op_q == OpLd) || (op_q == OpAdd) || (op_q == OpSub);
    assign op_is_sto = (op_q == OpSto);

`ifndef BIP_BRANCH_EN
    logic unused_acc_zero;
    assign unused_acc_zero = bus.i_acc_zero;
`endif

    // State, latched opcode and MEM wait counter; synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: instruction sequencing, decode and MEM timeout.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                op_d = bus.i_opcode;
                case (bus.i_opcode)
                    OpHlt: state_d = StHalt;
                    OpLdi, OpAddi, OpSubi: state_d = StExec;
                    OpSto, OpLd, OpAdd, OpSub: begin
                        state_d = StMem;
                        cnt_d   = '0;
                    end
`ifdef BIP_BRANCH_EN
                    OpBeq, OpBne, OpJmp: state_d = StExec;
`endif
                    default: state_d = StErr;
                endcase
            end
            StMem: begin
                // Ready takes priority over the timeout in the same cycle.
                if (bus.i_mem_ready) begin
                    state_d = StExec;
                end else if (cnt_q == MemLimit) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StExec: begin
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StErr;
            end
        endcase
    end

    // Moore strobes from state and latched opcode (PcSel also looks at ACC==0).
    always_comb begin
        bus.o_IrLd   = 1'b0;
        bus.o_WrPC   = 1'b0;
        bus.o_PcSel  = 1'b0;
        bus.o_SelA   = 2'b11;
        bus.o_SelB   = 1'b0;
        bus.o_WrAcc  = 1'b0;
        bus.o_Op     = 1'b0;
        bus.o_WrRam  = 1'b0;
        bus.o_RdRam  = 1'b0;
        bus.o_busy   = 1'b0;
        bus.o_halted = 1'b0;
        bus.o_err    = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StFetch: begin
                bus.o_IrLd = 1'b1;
                bus.o_busy = 1'b1;
            end
            StDecode: begin
                bus.o_busy = 1'b1;
            end
            StMem: begin
                bus.o_busy  = 1'b1;
                bus.o_RdRam = op_is_rd;
                bus.o_WrRam = op_is_sto;
            end
            StExec: begin
                bus.o_busy  = 1'b1;
                bus.o_WrPC  = 1'b1;
                // Read data must stay on the bus while ACC captures it.
                bus.o_RdRam = op_is_rd;
                case (op_q)
                    OpLd: begin
                        bus.o_SelA  = 2'b00;
                        bus.o_WrAcc = 1'b1;
                    end
                    OpLdi: begin
                        bus.o_SelA  = 2'b01;
                        bus.o_WrAcc = 1'b1;
                    end
                    OpAdd, OpSub: begin
                        bus.o_SelA  = 2'b10;
                        bus.o_SelB  = 1'b0;
                        bus.o_WrAcc = 1'b1;
                        bus.o_Op    = (op_q == OpSub);
                    end
                    OpAddi, OpSubi: begin
                        bus.o_SelA  = 2'b10;
                        bus.o_SelB  = 1'b1;
                        bus.o_WrAcc = 1'b1;
                        bus.o_Op    = (op_q == OpSubi);
                    end
`ifdef BIP_BRANCH_EN
                    OpJmp: bus.o_PcSel = 1'b1;
                    OpBeq: bus.o_PcSel = bus.i_acc_zero;
                    OpBne: bus.o_PcSel = !bus.i_acc_zero;
`endif
                    default: begin
                    end
                endcase
            end
            StHalt: begin
                bus.o_halted = 1'b1;
            end
            StErr: begin
                bus.o_err = 1'b1;
            end
            default: begin
                bus.o_err = 1'b1;
            end
        endcase
    end

endmodule
